stg_mem_lsu: RTL and testbench
==============================

Name: stg_mem_lsu

Overview:
Memory-access stage directly downstream of stg_ex. It consumes the EX results (ow_addr, ow_result, ow_tgt_gp, ow_tgt_gp_we, ow_opc, ow_pc) and issues loads and stores to the data memory port using a req/ack handshake. It stalls upstream while an access is outstanding and presents writeback data to the WB stage. Check-only ops (CLDcso/CSTcso) and non-memory ops pass through with no bus activity.

Parameters:
ADDR_W, 48, address width (matches `HBIT_ADDR+1`)
DATA_W, 24, data width (matches `HBIT_DATA+1`)
TIMEOUT, 255, cycles in WAIT without ack before a bus fault; legal range is 1 to 2^16-1

Ports:
iw_clk  in  1  clock
iw_rst  in  1  reset, synchronous, active-high
iw_pc  in  ADDR_W  PC of the instruction from EX
iw_opc  in  `HBIT_OPC+1  opcode from EX
iw_addr  in  ADDR_W  effective address from EX
iw_result  in  DATA_W  EX result, used as store data for stores
iw_tgt_gp  in  `HBIT_TGT_GP+1  destination GP register
iw_tgt_gp_we  in  1  GP write enable from EX
iw_flush  in  1  squash the instruction being captured
iw_stall  in  1  downstream (WB) stall
ow_stall  out  1  stall request to upstream; high while busy
ow_pc / ow_opc / ow_tgt_gp  out  widths as inputs  registered copies
ow_tgt_gp_we  out  1  writeback enable
ow_result  out  DATA_W  load data or pass-through result
ow_mem_req  out  1  bus request
ow_mem_we  out  1  1 = store
ow_mem_addr  out  ADDR_W  bus address
ow_mem_wdata  out  DATA_W  store data
iw_mem_ack  in  1  bus acknowledge (single-cycle pulse)
iw_mem_rdata  in  DATA_W  load data; valid when iw_mem_ack=1
ow_fault  out  1  one-cycle pulse on bus timeout
ow_fault_pc  out  ADDR_W  PC of the faulting access; held until the next fault

Behaviour:
- Reset: state IDLE. All outputs are 0, counter is 0.
- States: IDLE, WAIT, HOLD.
- IDLE with iw_stall=0 captures the inputs every cycle.
  - iw_flush=1: outputs register as a bubble (opc=0, we=0).
  - Non-memory or check-only op: outputs are registered after 1 cycle, with ow_result=iw_result.
  - Load (is_load) or store (is_store): on the next edge, drive ow_mem_req=1 with addr/we/wdata latched, set ow_tgt_gp_we=0, and move to WAIT.
- ow_stall = (state != IDLE), combinational. Upstream holds its inputs while this is high.
- WAIT: req, addr, we and wdata are held stable until ack. Counter increments each cycle.
  - Ack arrives with iw_stall=0: req drops on the next edge. A load sets ow_result=iw_mem_rdata and ow_tgt_gp_we=latched we. A store sets we=0. Next state is IDLE. Load-to-WB latency is 2 cycles for a same-cycle ack.
  - Ack arrives with iw_stall=1: req drops and rdata is captured into the skid register. Next state is HOLD.
  - Counter reaches TIMEOUT with no ack: req drops, ow_fault=1 for 1 cycle, ow_fault_pc=latched pc, writeback is suppressed, next state is IDLE. An ack arriving in the same cycle as the timeout wins: no fault is raised.
- HOLD: outputs stay frozen while iw_stall=1. When iw_stall=0, present the skid data and writeback, then go to IDLE.
- iw_stall=1 in IDLE: all outputs hold and no capture happens.
- iw_flush never aborts an in-flight access.
- iw_rst in any state: return to IDLE immediately. Req drops in the same edge, and any pending ack is ignored.
- Ack seen in IDLE (spurious): ignored.

Decomposition:
- Add to the shared opcode header: is_load(opc) covering the LD* family, and is_store(opc) covering STcso, STui and STsi. CLD*/CST* are excluded from both.
- Add the state encodings (IDLE=0, WAIT=1, HOLD=2) to a new include, src/lsu.vh.
- Sub-module lsu_timeout_ctr: TIMEOUT counter with clear, enable and a "hit" output.

Test Plan:
- LDcso, addr=106, ack after 3 cycles with rdata=24'h00ABCD: ow_stall high for 3 cycles, ow_result=00ABCD, ow_tgt_gp_we=1, req high for exactly 3 cycles.
- STcso, addr=206, result=24'h112233, ack on the first cycle: ow_mem_we=1, wdata=112233, ow_tgt_gp_we=0, ow_stall high for 1 cycle.
- LUIui then CSTcso: no ow_mem_req at any point, 1-cycle pass-through, ow_result=iw_result.
- Load with iw_stall=1 at ack time, held 4 cycles: state HOLD, ow_result presented once after stall release, no second req.
- Load, no ack, TIMEOUT=8: ow_fault pulses on cycle 8, ow_fault_pc=48'h600, ow_tgt_gp_we=0, ow_stall drops afterwards.
- iw_rst asserted mid-WAIT: on the next edge ow_mem_req=0 and all outputs are 0; a subsequent ack is ignored.

Source files
------------

// File: rtl/stg_mem_lsu_pkg.sv
// stg_mem_lsu_pkg: shared widths, opcode map, LSU state encoding and opcode class helpers.
package stg_mem_lsu_pkg;
   localparam int HBIT_ADDR   = 47;
   localparam int HBIT_DATA   = 23;
   localparam int HBIT_OPC    = 7;
   localparam int HBIT_TGT_GP = 3;
   localparam logic [HBIT_OPC:0] OPC_NOP    = 8'h00;
   localparam logic [HBIT_OPC:0] OPC_LUIUI  = 8'h01;
   localparam logic [HBIT_OPC:0] OPC_LDCSO  = 8'h10;
   localparam logic [HBIT_OPC:0] OPC_LDUI   = 8'h11;
   localparam logic [HBIT_OPC:0] OPC_LDSI   = 8'h12;
   localparam logic [HBIT_OPC:0] OPC_STCSO  = 8'h18;
   localparam logic [HBIT_OPC:0] OPC_STUI   = 8'h19;
   localparam logic [HBIT_OPC:0] OPC_STSI   = 8'h1A;
   localparam logic [HBIT_OPC:0] OPC_CLDCSO = 8'h20;
   localparam logic [HBIT_OPC:0] OPC_CSTCSO = 8'h21;
   typedef enum logic [1:0] {S_IDLE = 2'd0, S_WAIT = 2'd1, S_HOLD = 2'd2} lsu_state_t;
   // Check-only CLD*/CST* never touch the bus, so they belong to neither class.
   function automatic logic is_load(input logic [HBIT_OPC:0] opc);
      return opc inside {OPC_LDCSO, OPC_LDUI, OPC_LDSI};
   endfunction
   function automatic logic is_store(input logic [HBIT_OPC:0] opc);
      return opc inside {OPC_STCSO, OPC_STUI, OPC_STSI};
   endfunction
endpackage

// File: rtl/stg_mem_lsu_timeout_ctr.sv
// lsu_timeout_ctr: counts enabled cycles since clear; hit marks the TIMEOUT-th enabled cycle.
module lsu_timeout_ctr #(
   parameter int TIMEOUT = 255
) (
   input  logic iw_clk,
   input  logic iw_rst,
   input  logic iw_clr,
   input  logic iw_en,
   output logic ow_hit
);
   logic [15:0] r_cnt;
   always_ff @(posedge iw_clk) begin
      if (iw_rst || iw_clr) r_cnt <= '0;
      else if (iw_en) r_cnt <= r_cnt + 16'd1;
   end
   assign ow_hit = iw_en && (r_cnt == 16'(TIMEOUT - 1));
endmodule

// File: rtl/stg_mem_lsu.sv
// stg_mem_lsu: memory stage issuing loads/stores over a req/ack bus, with timeout fault and WB skid.
module stg_mem_lsu
   import stg_mem_lsu_pkg::*;
#(
   parameter int ADDR_W  = 48,
   parameter int DATA_W  = 24,
   parameter int TIMEOUT = 255
) (
   input  logic                  iw_clk,
   input  logic                  iw_rst,
   input  logic [ADDR_W-1:0]     iw_pc,
   input  logic [HBIT_OPC:0]     iw_opc,
   input  logic [ADDR_W-1:0]     iw_addr,
   input  logic [DATA_W-1:0]     iw_result,
   input  logic [HBIT_TGT_GP:0]  iw_tgt_gp,
   input  logic                  iw_tgt_gp_we,
   input  logic                  iw_flush,
   input  logic                  iw_stall,
   output logic                  ow_stall,
   output logic [ADDR_W-1:0]     ow_pc,
   output logic [HBIT_OPC:0]     ow_opc,
   output logic [HBIT_TGT_GP:0]  ow_tgt_gp,
   output logic                  ow_tgt_gp_we,
   output logic [DATA_W-1:0]     ow_result,
   output logic                  ow_mem_req,
   output logic                  ow_mem_we,
   output logic [ADDR_W-1:0]     ow_mem_addr,
   output logic [DATA_W-1:0]     ow_mem_wdata,
   input  logic                  iw_mem_ack,
   input  logic [DATA_W-1:0]     iw_mem_rdata,
   output logic                  ow_fault,
   output logic [ADDR_W-1:0]     ow_fault_pc
);
   lsu_state_t          r_state;
   logic [ADDR_W-1:0]   r_pc, r_addr, r_fault_pc;
   logic [HBIT_OPC:0]   r_opc;
   logic [HBIT_TGT_GP:0] r_tgt;
   logic [DATA_W-1:0]   r_result, r_wdata, r_skid;
   logic                r_we, r_lat_we, r_req, r_mem_we, r_fault;
   logic                w_mem, w_hit;
   assign w_mem = is_load(iw_opc) || is_store(iw_opc);
   lsu_timeout_ctr #(.TIMEOUT(TIMEOUT)) u_ctr (
      .iw_clk(iw_clk),
      .iw_rst(iw_rst),
      .iw_clr(r_state != S_WAIT),
      .iw_en (r_state == S_WAIT),
      .ow_hit(w_hit)
   );
   always_ff @(posedge iw_clk) begin
      if (iw_rst) begin
         r_state    <= S_IDLE;
         r_pc       <= '0;
         r_opc      <= '0;
         r_tgt      <= '0;
         r_we       <= 1'b0;
         r_lat_we   <= 1'b0;
         r_result   <= '0;
         r_req      <= 1'b0;
         r_mem_we   <= 1'b0;
         r_addr     <= '0;
         r_wdata    <= '0;
         r_skid     <= '0;
         r_fault    <= 1'b0;
         r_fault_pc <= '0;
      end else begin
         r_fault <= 1'b0;
         case (r_state)
            S_IDLE: if (!iw_stall) begin
               r_pc  <= iw_pc;
               r_tgt <= iw_tgt_gp;
               if (iw_flush) begin
                  r_opc    <= '0;
                  r_we     <= 1'b0;
                  r_result <= '0;
               end else if (w_mem) begin
                  r_opc    <= iw_opc;
                  r_we     <= 1'b0;
                  r_lat_we <= iw_tgt_gp_we;
                  r_req    <= 1'b1;
                  r_mem_we <= is_store(iw_opc);
                  r_addr   <= iw_addr;
                  r_wdata  <= iw_result;
                  r_state  <= S_WAIT;
               end else begin
                  r_opc    <= iw_opc;
                  r_we     <= iw_tgt_gp_we;
                  r_result <= iw_result;
               end
            end
            // Ack is checked before the timeout so a same-cycle ack suppresses the fault.
            S_WAIT: if (iw_mem_ack) begin
               r_req <= 1'b0;
               if (iw_stall) begin
                  r_skid  <= iw_mem_rdata;
                  r_state <= S_HOLD;
               end else begin
                  if (!r_mem_we) r_result <= iw_mem_rdata;
                  r_we    <= !r_mem_we && r_lat_we;
                  r_state <= S_IDLE;
               end
            end else if (w_hit) begin
               r_req      <= 1'b0;
               r_fault    <= 1'b1;
               r_fault_pc <= r_pc;
               r_we       <= 1'b0;
               r_state    <= S_IDLE;
            end
            S_HOLD: if (!iw_stall) begin
               if (!r_mem_we) r_result <= r_skid;
               r_we    <= !r_mem_we && r_lat_we;
               r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end
   assign ow_stall     = r_state != S_IDLE;
   assign ow_pc        = r_pc;
   assign ow_opc       = r_opc;
   assign ow_tgt_gp    = r_tgt;
   assign ow_tgt_gp_we = r_we;
   assign ow_result    = r_result;
   assign ow_mem_req   = r_req;
   assign ow_mem_we    = r_mem_we;
   assign ow_mem_addr  = r_addr;
   assign ow_mem_wdata = r_wdata;
   assign ow_fault     = r_fault;
   assign ow_fault_pc  = r_fault_pc;
endmodule

// File: tb/tb_stg_mem_lsu.sv
// tb_stg_mem_lsu: directed checks of stg_mem_lsu (TIMEOUT=8) with hand-computed expectations.
module tb_stg_mem_lsu;
   import stg_mem_lsu_pkg::*;
   logic        clk = 1'b0, rst = 1'b1;
   logic [47:0] pc, addr;
   logic [7:0]  opc;
   logic [23:0] result, rdata;
   logic [3:0]  tgt;
   logic        we, flush, stall, ack;
   logic        o_stall, o_we, o_req, o_mem_we, o_fault;
   logic [47:0] o_pc, o_addr, o_fault_pc;
   logic [7:0]  o_opc;
   logic [3:0]  o_tgt;
   logic [23:0] o_result, o_wdata;
   int          n_err = 0, n_chk = 0, cnt;
   logic        seen;
   stg_mem_lsu #(.ADDR_W(48), .DATA_W(24), .TIMEOUT(8)) dut (
      .iw_clk(clk), .iw_rst(rst), .iw_pc(pc), .iw_opc(opc), .iw_addr(addr),
      .iw_result(result), .iw_tgt_gp(tgt), .iw_tgt_gp_we(we), .iw_flush(flush),
      .iw_stall(stall), .ow_stall(o_stall), .ow_pc(o_pc), .ow_opc(o_opc),
      .ow_tgt_gp(o_tgt), .ow_tgt_gp_we(o_we), .ow_result(o_result),
      .ow_mem_req(o_req), .ow_mem_we(o_mem_we), .ow_mem_addr(o_addr),
      .ow_mem_wdata(o_wdata), .iw_mem_ack(ack), .iw_mem_rdata(rdata),
      .ow_fault(o_fault), .ow_fault_pc(o_fault_pc)
   );
   always #5 clk = ~clk;
   task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic drive(input logic [7:0] o, input logic [47:0] p, input logic [47:0] a,
                        input logic [23:0] r, input logic [3:0] t, input logic w);
      opc = o; pc = p; addr = a; result = r; tgt = t; we = w;
   endtask
   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end
   initial begin
      drive(OPC_NOP, 0, 0, 0, 0, 0);
      flush = 0; stall = 0; ack = 0; rdata = 0;
      tick(); tick();
      chk("rst_stall", o_stall, 0);
      chk("rst_req", o_req, 0);
      chk("rst_result", o_result, 0);
      chk("rst_we", o_we, 0);
      chk("rst_fault", o_fault, 0);
      chk("rst_fault_pc", o_fault_pc, 0);
      rst = 0;
      drive(OPC_LDCSO, 48'h100, 48'd106, 24'h0, 4'd3, 1'b1);
      tick();
      drive(OPC_NOP, 0, 0, 0, 0, 0);
      chk("ld_addr", o_addr, 48'd106);
      chk("ld_mem_we", o_mem_we, 0);
      chk("ld_we_wait", o_we, 0);
      cnt = 0;
      for (int i = 0; i < 3; i++) begin
         if (o_req && o_stall) cnt++;
         if (i == 2) begin ack = 1; rdata = 24'h00ABCD; end
         tick();
      end
      ack = 0;
      chk("ld_req_cycles", cnt, 3);
      chk("ld_req_drop", o_req, 0);
      chk("ld_stall_drop", o_stall, 0);
      chk("ld_result", o_result, 24'h00ABCD);
      chk("ld_we", o_we, 1);
      chk("ld_tgt", o_tgt, 3);
      drive(OPC_STCSO, 48'h200, 48'd206, 24'h112233, 4'd5, 1'b0);
      tick();
      drive(OPC_NOP, 0, 0, 0, 0, 0);
      chk("st_req", o_req, 1);
      chk("st_mem_we", o_mem_we, 1);
      chk("st_wdata", o_wdata, 24'h112233);
      chk("st_addr", o_addr, 48'd206);
      chk("st_stall", o_stall, 1);
      ack = 1;
      tick();
      ack = 0;
      chk("st_stall_drop", o_stall, 0);
      chk("st_req_drop", o_req, 0);
      chk("st_we", o_we, 0);
      drive(OPC_LUIUI, 48'h300, 48'h0, 24'h0000AA, 4'd2, 1'b1);
      tick();
      chk("lui_req", o_req, 0);
      chk("lui_stall", o_stall, 0);
      chk("lui_result", o_result, 24'h0000AA);
      chk("lui_we", o_we, 1);
      drive(OPC_CSTCSO, 48'h304, 48'h44, 24'h000055, 4'd0, 1'b0);
      tick();
      chk("cst_req", o_req, 0);
      chk("cst_opc", o_opc, OPC_CSTCSO);
      chk("cst_result", o_result, 24'h000055);
      drive(OPC_LDCSO, 48'h308, 48'h48, 24'h0, 4'd1, 1'b1);
      flush = 1;
      tick();
      flush = 0;
      drive(OPC_NOP, 0, 0, 0, 0, 0);
      chk("flush_req", o_req, 0);
      chk("flush_opc", o_opc, 0);
      chk("flush_we", o_we, 0);
      drive(OPC_LDSI, 48'h400, 48'h30, 24'h0, 4'd7, 1'b1);
      tick();
      drive(OPC_NOP, 0, 0, 0, 0, 0);
      chk("hold_req", o_req, 1);
      ack = 1; rdata = 24'h777777; stall = 1;
      tick();
      ack = 0;
      for (int i = 0; i < 3; i++) begin
         chk("hold_stall", o_stall, 1);
         chk("hold_req_low", o_req, 0);
         chk("hold_we", o_we, 0);
         tick();
      end
      stall = 0;
      tick();
      chk("hold_result", o_result, 24'h777777);
      chk("hold_wb_we", o_we, 1);
      chk("hold_exit", o_stall, 0);
      tick();
      chk("hold_no_req", o_req, 0);
      chk("hold_once", o_we, 0);
      drive(OPC_LDCSO, 48'h600, 48'h60, 24'h0, 4'd4, 1'b1);
      tick();
      drive(OPC_NOP, 0, 0, 0, 0, 0);
      cnt = 0; seen = 0;
      for (int i = 0; i < 20 && !seen; i++) begin
         if (o_fault) seen = 1;
         else begin
            if (o_req) cnt++;
            tick();
         end
      end
      chk("to_seen", seen, 1);
      chk("to_req_cycles", cnt, 8);
      chk("to_fault_pc", o_fault_pc, 48'h600);
      chk("to_we", o_we, 0);
      chk("to_req", o_req, 0);
      chk("to_stall", o_stall, 0);
      tick();
      chk("to_pulse", o_fault, 0);
      chk("to_pc_held", o_fault_pc, 48'h600);
      drive(OPC_LDUI, 48'h700, 48'h70, 24'h0, 4'd6, 1'b1);
      tick();
      drive(OPC_NOP, 0, 0, 0, 0, 0);
      tick();
      chk("rw_req", o_req, 1);
      rst = 1;
      tick();
      chk("rw_req_drop", o_req, 0);
      chk("rw_stall", o_stall, 0);
      chk("rw_opc", o_opc, 0);
      chk("rw_addr", o_addr, 0);
      chk("rw_fault_pc", o_fault_pc, 0);
      rst = 0; ack = 1; rdata = 24'h999999;
      tick();
      ack = 0;
      chk("rw_ack_ignored", o_result, 0);
      chk("rw_ack_we", o_we, 0);
      chk("rw_ack_req", o_req, 0);
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
